// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch stage, instruction memory and decode
// for the fetch queue. The queue itself uses the slave modport.
interface fetch_queue_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          pc_valid;
  logic [AW-1:0] pc;
  logic          pc_ready;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic          flush;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_instr;
  logic          out_ready;

  modport master (
    output pc_valid, pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, flush, out_ready,
    input  pc_ready, mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr
  );

  modport slave (
    input  pc_valid, pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, flush, out_ready,
    output pc_ready, mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: allocates a slot per issued PC, fills slots from
// in-order memory responses and presents filled entries to decode in order.
// A flush empties the queue and counts the still-outstanding responses so
// they can be discarded when they return.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.slave  fq,
  output logic          err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    slot_pc    [DEPTH];
  logic [DW-1:0]    slot_instr [DEPTH];
  logic [DEPTH-1:0] slot_filled;

  logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr;
  logic [CW-1:0] count;     // allocated slots
  logic [CW-1:0] pend_cnt;  // allocated slots still waiting for data
  logic [CW-1:0] drop_cnt;  // responses still owed to flushed requests

  logic not_full, out_vld, accept, pop;
  logic rsp, rsp_ok, rsp_drop, rsp_fill, rsp_spur;

  // Handshake decode; stall terms use registered occupancy only.
  assign not_full          = (count < CW'(DEPTH));
  assign fq.pc_ready       = rst_n && !fq.flush && not_full && fq.mem_req_ready;
  assign fq.mem_req_valid  = rst_n && fq.pc_valid && !fq.flush && not_full;
  assign fq.mem_req_addr   = fq.pc;
  assign out_vld           = rst_n && slot_filled[head_ptr] && (count != '0);
  assign fq.out_valid      = out_vld;
  assign fq.out_pc         = slot_pc[head_ptr];
  assign fq.out_instr      = slot_instr[head_ptr];

  assign accept   = fq.pc_valid && fq.pc_ready;
  assign pop      = out_vld && fq.out_ready && !fq.flush;

  // A response is owed either to a flushed request or to an unfilled slot;
  // anything else is spurious.
  assign rsp      = rst_n && fq.mem_rsp_valid;
  assign rsp_ok   = rsp && ((drop_cnt != '0) || (pend_cnt != '0));
  assign rsp_drop = rsp && (drop_cnt != '0);
  assign rsp_fill = rsp && (drop_cnt == '0) && (pend_cnt != '0) && !fq.flush;
  assign rsp_spur = rsp && !rsp_ok;

  // Control state: pointers, occupancy counters, filled bits, error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      count       <= '0;
      pend_cnt    <= '0;
      drop_cnt    <= '0;
      slot_filled <= '0;
      err         <= 1'b0;
    end else if (fq.flush) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      count       <= '0;
      pend_cnt    <= '0;
      slot_filled <= '0;
      drop_cnt    <= pend_cnt + drop_cnt - CW'(rsp_ok);
      if (rsp_spur) err <= 1'b1;
    end else begin
      alloc_ptr <= alloc_ptr + PW'(accept);
      fill_ptr  <= fill_ptr + PW'(rsp_fill);
      head_ptr  <= head_ptr + PW'(pop);
      count     <= count + CW'(accept) - CW'(pop);
      pend_cnt  <= pend_cnt + CW'(accept) - CW'(rsp_fill);
      drop_cnt  <= drop_cnt - CW'(rsp_drop);
      if (accept)   slot_filled[alloc_ptr] <= 1'b0;
      if (rsp_fill) slot_filled[fill_ptr]  <= 1'b1;
      if (pop)      slot_filled[head_ptr]  <= 1'b0;
      if (rsp_spur) err <= 1'b1;
    end
  end

  // Slot payload: PC on allocation, instruction on fill; not reset.
  always_ff @(posedge clk) begin
    if (accept)   slot_pc[alloc_ptr]   <= fq.pc;
    if (rsp_fill) slot_instr[fill_ptr] <= fq.mem_rsp_data;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model and an in-order memory model.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  always #5 clk = ~clk;

  fetch_queue_if #(.AW(32), .DW(32)) fq();

  fetch_queue #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .fq(fq.slave), .err(err)
  );

  int tests = 0;
  int fails = 0;

  typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
  typedef struct { logic [31:0] addr; int due; } req_t;
  ent_t mq[$];
  req_t memq[$];
  int   m_drop = 0;
  bit   m_err  = 1'b0;
  int   cyc    = 0;
  int   cur_lat = 1;
  bit   spur_inj = 1'b0;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic bit p_pc_ready();
    return rst_n && !fq.flush && (mq.size() < DEPTH) && fq.mem_req_ready;
  endfunction

  function automatic bit p_req_valid();
    return rst_n && fq.pc_valid && !fq.flush && (mq.size() < DEPTH);
  endfunction

  function automatic bit p_out_valid();
    return rst_n && (mq.size() > 0) && mq[0].filled;
  endfunction

  task automatic drive_mem();
    if (rst_n && spur_inj) begin
      fq.mem_rsp_valid = 1'b1; fq.mem_rsp_data = 32'hDEADBEEF;
    end else if (rst_n && memq.size() > 0 && memq[0].due <= cyc) begin
      fq.mem_rsp_valid = 1'b1; fq.mem_rsp_data = instr_of(memq[0].addr);
    end else begin
      fq.mem_rsp_valid = 1'b0; fq.mem_rsp_data = '0;
    end
  endtask

  task automatic model_update();
    bit acc, pop, rsp, from_mem;
    int unf, idx;
    acc = fq.pc_valid && p_pc_ready();
    pop = p_out_valid() && fq.out_ready && !fq.flush;
    rsp = fq.mem_rsp_valid;
    from_mem = rsp && !spur_inj;
    if (!rst_n) begin
      mq.delete(); memq.delete(); m_drop = 0; m_err = 1'b0;
      return;
    end
    if (from_mem) void'(memq.pop_front());
    if (fq.flush) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      if (rsp) begin
        if (m_drop + unf > 0) m_drop = m_drop + unf - 1;
        else m_err = 1'b1;
      end else m_drop = m_drop + unf;
      mq.delete();
    end else begin
      if (rsp) begin
        if (m_drop > 0) m_drop--;
        else begin
          idx = -1;
          foreach (mq[i]) if (idx < 0 && !mq[i].filled) idx = i;
          if (idx >= 0) begin mq[idx].filled = 1'b1; mq[idx].instr = fq.mem_rsp_data; end
          else m_err = 1'b1;
        end
      end
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{pc: fq.pc, instr: 32'h0, filled: 1'b0});
        memq.push_back('{addr: fq.pc, due: cyc + cur_lat});
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_idle();
    fq.pc_valid = 1'b0; fq.pc = '0; fq.flush = 1'b0; fq.out_ready = 1'b0;
    fq.mem_req_ready = 1'b1; spur_inj = 1'b0; cur_lat = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; set_idle(); drive_mem();
    @(negedge clk); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle(); rst_n = 1'b0; fq.pc_valid = 1'b1; fq.pc = 32'h40; drive_mem();
    @(negedge clk);
    tests++; if (fq.pc_ready !== 1'b0) begin fails++; $display("FAIL rst_pc_ready: got %b want 0", fq.pc_ready); end
    tests++; if (fq.mem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid: got %b want 0", fq.mem_req_valid); end
    tests++; if (fq.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", fq.out_valid); end
    tick(); tick();
    rst_n = 1'b1; fq.pc_valid = 1'b0; drive_mem();
    @(negedge clk);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err); end
    tests++; if (fq.out_valid !== 1'b0) begin fails++; $display("FAIL post_rst_out_valid: got %b want 0", fq.out_valid); end
    tests++; if (fq.pc_ready !== 1'b1) begin fails++; $display("FAIL post_rst_pc_ready: got %b want 1", fq.pc_ready); end
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] gpc[$], gin[$];
    int gk[$];
    do_reset(); fq.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      fq.pc_valid = (k < 3); fq.pc = 32'(4 * k); drive_mem();
      @(negedge clk);
      if (k < 3) begin
        tests++; if (fq.mem_req_valid !== 1'b1 || fq.mem_req_addr !== fq.pc) begin
          fails++; $display("FAIL stream_req: got v=%b a=%0h want v=1 a=%0h", fq.mem_req_valid, fq.mem_req_addr, fq.pc); end
      end
      if (fq.out_valid === 1'b1) begin gpc.push_back(fq.out_pc); gin.push_back(fq.out_instr); gk.push_back(k); end
      tick();
    end
    tests++;
    if (gpc.size() != 3) begin fails++; $display("FAIL stream_count: got %0d want 3", gpc.size()); end
    else for (int i = 0; i < 3; i++) begin
      tests++; if (gpc[i] !== 32'(4 * i) || gin[i] !== instr_of(32'(4 * i)) || gk[i] != i + 2) begin
        fails++; $display("FAIL stream_out%0d: got pc=%0h instr=%0h cyc=%0d want pc=%0h instr=%0h cyc=%0d",
                          i, gpc[i], gin[i], gk[i], 4 * i, instr_of(32'(4 * i)), i + 2); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] nxt;
    logic [31:0] got[$];
    do_reset(); nxt = 32'h0;
    for (int k = 0; k < 6; k++) begin
      fq.pc_valid = 1'b1; fq.pc = nxt; drive_mem();
      @(negedge clk);
      if (k >= 4) begin
        tests++; if (fq.pc_ready !== 1'b0) begin fails++; $display("FAIL bp_full_stall%0d: got %b want 0", k, fq.pc_ready); end
      end
      if (p_pc_ready()) nxt += 32'h4;
      tick();
    end
    tests++; if (dut.count !== 3'd4) begin fails++; $display("FAIL bp_count: got %0d want 4", dut.count); end
    fq.out_ready = 1'b1; fq.pc = nxt; drive_mem();
    @(negedge clk);
    tests++; if (fq.pc_ready !== 1'b0) begin fails++; $display("FAIL bp_full_pop_stall: got %b want 0", fq.pc_ready); end
    tests++; if (fq.out_valid !== 1'b1 || fq.out_pc !== 32'h0) begin
      fails++; $display("FAIL bp_head: got v=%b pc=%0h want v=1 pc=0", fq.out_valid, fq.out_pc); end
    tick();
    fq.out_ready = 1'b0; drive_mem();
    @(negedge clk);
    tests++; if (fq.pc_ready !== 1'b1) begin fails++; $display("FAIL bp_resume: got %b want 1", fq.pc_ready); end
    tests++; if (fq.out_pc !== 32'h4) begin fails++; $display("FAIL bp_head2: got %0h want 4", fq.out_pc); end
    tick();
    fq.pc_valid = 1'b0; fq.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive_mem(); @(negedge clk);
      if (fq.out_valid === 1'b1) got.push_back(fq.out_pc);
      tick();
    end
    tests++;
    if (got.size() != 4) begin fails++; $display("FAIL bp_drain_count: got %0d want 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      tests++; if (got[i] !== 32'(4 * (i + 1))) begin fails++; $display("FAIL bp_drain%0d: got %0h want %0h", i, got[i], 4 * (i + 1)); end
    end
  endtask

  // Issue three PCs with given latencies, flush on the cycle after (plus
  // `gap` idle cycles), then check the post-flush PC comes back intact.
  task automatic flush_case(input string nm, input int l0, input int l1, input int gap,
                            input logic [31:0] base, input logic [31:0] npc);
    logic [31:0] fpc, fin;
    bit found;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      fq.pc_valid = 1'b1; fq.pc = base + 32'(4 * k); cur_lat = (k == 0) ? l0 : l1;
      drive_mem(); @(negedge clk); tick();
    end
    fq.pc_valid = 1'b0;
    for (int k = 0; k < gap; k++) begin drive_mem(); @(negedge clk); tick(); end
    fq.flush = 1'b1; drive_mem(); @(negedge clk); tick();
    fq.flush = 1'b0; fq.pc_valid = 1'b1; fq.pc = npc; cur_lat = 1; fq.out_ready = 1'b1; drive_mem();
    @(negedge clk);
    tests++; if (fq.out_valid !== 1'b0) begin fails++; $display("FAIL %s_out_valid: got %b want 0", nm, fq.out_valid); end
    tests++; if (dut.drop_cnt !== 3'd2) begin fails++; $display("FAIL %s_drop_cnt: got %0d want 2", nm, dut.drop_cnt); end
    tick();
    fq.pc_valid = 1'b0; found = 1'b0; fpc = '0; fin = '0;
    for (int k = 0; k < 14; k++) begin
      drive_mem(); @(negedge clk);
      if (!found && fq.out_valid === 1'b1) begin found = 1'b1; fpc = fq.out_pc; fin = fq.out_instr; end
      tick();
    end
    tests++; if (!found || fpc !== npc || fin !== instr_of(npc)) begin
      fails++; $display("FAIL %s_post_pc: got seen=%b pc=%0h instr=%0h want pc=%0h instr=%0h",
                        nm, found, fpc, fin, npc, instr_of(npc)); end
    tests++; if (dut.drop_cnt !== 3'd0 || err !== 1'b0) begin
      fails++; $display("FAIL %s_final: got drop=%0d err=%b want drop=0 err=0", nm, dut.drop_cnt, err); end
  endtask

  task automatic test_flush();
    // First PC fills quickly, two stay outstanding, flush cycle has no response.
    flush_case("flush", 1, 5, 0, 32'h20, 32'h100);
    // Three outstanding, flush coincides with the first response.
    flush_case("flush_rsp", 3, 5, 0, 32'h30, 32'h200);
  endtask

  task automatic test_spurious();
    do_reset();
    spur_inj = 1'b1; drive_mem(); @(negedge clk); tick();
    spur_inj = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_mem(); @(negedge clk);
      tests++; if (err !== 1'b1 || fq.out_valid !== 1'b0) begin
        fails++; $display("FAIL spur_sticky%0d: got err=%b ov=%b want err=1 ov=0", k, err, fq.out_valid); end
      tick();
    end
    do_reset(); drive_mem(); @(negedge clk);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL spur_clear: got %b want 0", err); end
    tick();
  endtask

  task automatic test_random(input string nm, input int n, input int flush_pct);
    logic [31:0] sb[$];
    logic [31:0] cur_pc;
    int offered, budget;
    do_reset(); offered = 0; budget = 2000; cur_pc = {$urandom_range(16'hFFFF), 2'b00};
    while (!(offered == n && mq.size() == 0 && memq.size() == 0) && budget > 0) begin
      budget--;
      fq.flush = (offered < n && m_drop == 0 && $urandom_range(99) < flush_pct);
      fq.pc_valid = (offered < n) && ($urandom_range(3) != 0);
      fq.pc = cur_pc;
      fq.out_ready = $urandom_range(1);
      fq.mem_req_ready = ($urandom_range(3) != 0);
      cur_lat = $urandom_range(3, 1);
      drive_mem();
      @(negedge clk);
      tests++; if (fq.pc_ready !== p_pc_ready()) begin fails++; $display("FAIL %s_pc_ready@%0d: got %b want %b", nm, cyc, fq.pc_ready, p_pc_ready()); end
      tests++; if (fq.mem_req_valid !== p_req_valid() || (p_req_valid() && fq.mem_req_addr !== fq.pc)) begin
        fails++; $display("FAIL %s_req@%0d: got v=%b a=%0h want v=%b a=%0h", nm, cyc, fq.mem_req_valid, fq.mem_req_addr, p_req_valid(), fq.pc); end
      tests++; if (fq.out_valid !== p_out_valid()) begin fails++; $display("FAIL %s_out_valid@%0d: got %b want %b", nm, cyc, fq.out_valid, p_out_valid()); end
      tests++; if (err !== m_err) begin fails++; $display("FAIL %s_err@%0d: got %b want %b", nm, cyc, err, m_err); end
      if (p_out_valid() && fq.out_ready && !fq.flush) begin
        tests++;
        if (sb.size() == 0) begin fails++; $display("FAIL %s_pop@%0d: got pc=%0h want no entry", nm, cyc, fq.out_pc); end
        else if (fq.out_pc !== sb[0] || fq.out_instr !== instr_of(sb[0])) begin
          fails++; $display("FAIL %s_pop@%0d: got pc=%0h instr=%0h want pc=%0h instr=%0h",
                            nm, cyc, fq.out_pc, fq.out_instr, sb[0], instr_of(sb[0])); end
        if (sb.size() > 0) void'(sb.pop_front());
      end
      if (fq.flush) sb.delete();
      if (fq.pc_valid && p_pc_ready()) begin
        sb.push_back(cur_pc); offered++; cur_pc = {$urandom_range(16'hFFFF), 2'b00};
      end
      tick();
    end
    tests++; if (budget == 0) begin fails++; $display("FAIL %s_timeout: got offered=%0d want %0d drained", nm, offered, n); end
  endtask

  initial begin
    set_idle(); fq.mem_rsp_valid = 1'b0; fq.mem_rsp_data = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_spurious();
    test_random("wrap", 10, 0);
    test_random("rnd_flush", 40, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish before 500000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue slots; power of two, 2..16.
REQ-002 Parameter AW, default 32, PC/address width.
REQ-003 Parameter DW, default 32, instruction width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 pc_valid  in  1  fetch stage presents a PC this cycle.
REQ-007 pc  in  AW  PC to fetch.
REQ-008 pc_ready  out  1  queue accepts pc this cycle; deasserted = stall to fetch stage.
REQ-009 mem_req_valid  out  1  instruction memory read request.
REQ-010 mem_req_addr  out  AW  request address, equal to pc.
REQ-011 mem_req_ready  in  1  memory accepts the request.
REQ-012 mem_rsp_valid  in  1  read data returned, in request order, at least 1 cycle after acceptance.
REQ-013 mem_rsp_data  in  DW  returned instruction.
REQ-014 flush  in  1  redirect: discard all queued and in-flight fetches.
REQ-015 out_valid  out  1  head entry holds a filled instruction.
REQ-016 out_pc  out  AW  PC of head entry.
REQ-017 out_instr  out  DW  instruction of head entry.
REQ-018 out_ready  in  1  decode consumes head entry.
REQ-019 err  out  1  sticky: response arrived with nothing outstanding or to drop.

Function
REQ-020 Storage: circular buffer of DEPTH slots {pc, instr, filled}; pointers alloc_ptr, fill_ptr, head_ptr; count = allocated slots, 0..DEPTH.
REQ-021 pc_ready = !flush && count < DEPTH && mem_req_ready; computed from registered count only (no path from out_ready).
REQ-022 mem_req_valid = pc_valid && !flush && count < DEPTH; mem_req_addr = pc.
REQ-023 Accept when pc_valid && pc_ready: write pc to slot[alloc_ptr], clear its filled bit, alloc_ptr+1 mod DEPTH.
REQ-024 Response with drop_cnt == 0: write mem_rsp_data to slot[fill_ptr], set filled, fill_ptr+1 mod DEPTH.
REQ-025 out_valid = slot[head_ptr].filled && count > 0; out_pc/out_instr driven from slot[head_ptr] combinationally.
REQ-026 Pop when out_valid && out_ready: clear filled, head_ptr+1 mod DEPTH.
REQ-027 count next = count + accept - pop; accept and pop in same cycle leave count unchanged.
REQ-028 Full (count == DEPTH): pc_ready low even if pop occurs that cycle; accept resumes next cycle.
REQ-029 Empty: out_valid low; an entry filled at cycle N is visible at out_valid in cycle N+1 (1-cycle response-to-output latency).
REQ-030 Flush cycle: no accept, no pop; all pointers, count and filled bits cleared next cycle.
REQ-031 Flush: drop_cnt next = (allocated-unfilled count) + drop_cnt - (1 if mem_rsp_valid that cycle); width clog2(DEPTH)+1.
REQ-032 Response with drop_cnt > 0: discarded, drop_cnt decremented; no slot written.
REQ-033 Accepts after flush proceed immediately; their responses follow dropped ones in order.
REQ-034 Response with drop_cnt == 0 and no unfilled allocated slot: ignored, err set until reset.
REQ-035 Flush with count == 0 and drop_cnt == 0: no state change besides holding empty.

Reset
REQ-036 On rst_n low at a rising edge: count, pointers, drop_cnt = 0; all filled bits = 0; err = 0.
REQ-037 During and after reset cycle: out_valid = 0, mem_req_valid = 0 while rst_n low, pc_ready = 0 while rst_n low.
REQ-038 Reset mid-operation abandons in-flight requests; responses after reset to an empty queue set err (bench holds memory quiet across reset).

Verification
REQ-039 Stream: PCs 0x0,0x4,0x8, memory latency 1, out_ready=1 -> out_pc 0x0,0x4,0x8 with matching instr, one per cycle after 2-cycle fill.
REQ-040 Backpressure: out_ready=0, DEPTH=4, 6 PCs offered -> 4 accepted, pc_ready low at count 4; one pop -> pc_ready high next cycle, 5th PC 0x10 accepted.
REQ-041 Flush with 2 outstanding, 1 filled -> next cycle out_valid=0, drop_cnt=2; next 2 responses discarded; post-flush PC 0x100 returns instr as out_pc 0x100.
REQ-042 Flush coinciding with a response, 3 outstanding -> drop_cnt=2; exactly 2 further responses dropped.
REQ-043 Spurious mem_rsp_valid on empty queue -> err=1 and stays 1 until rst_n low; out_valid stays 0.
REQ-044 Pointer wrap: 10 PCs through DEPTH=4 with random out_ready and latency 1..3 -> output order and PC/instr pairing exact.
